dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Wait-state data memory responder: one word access per req, registered ack.
// Optional misalignment trap is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic take;

  logic              wr_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              mis_q;
  logic              mis_in;

  logic              we;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       wval;

  logic [31:0] mem [0:(2**ADDR_W)-1];

  logic unused;
  assign unused = ^{addr[31:ADDR_W+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_in = (addr[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          take = 1'b1;
          if (WC == 4'd0) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = WC;
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_n = RESP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With no wait states the write lands on the accepting edge, so use live inputs
  always_comb begin
    we   = 1'b0;
    widx = idx_q;
    wval = wdata_q;
    if (take) begin
      widx = addr[ADDR_W+1:2];
      wval = wdata;
      we   = (WC == 4'd0) && wr && !mis_in;
    end else if (state == WAIT && state_n == RESP) begin
      we = wr_q && !mis_q;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[widx] <= wval;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      ack     <= 1'b0;
      rdata   <= '0;
    end else begin
      if (take) begin
        wr_q    <= wr;
        idx_q   <= addr[ADDR_W+1:2];
        wdata_q <= wdata;
        mis_q   <= mis_in;
      end
      ack <= (state == RESP);
      if (state == RESP && !wr_q && !mis_q) rdata <= mem[idx_q];
      else rdata <= '0;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else err <= (state == RESP) && mis_q;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus random traffic against
// a word-array model; a second instance covers zero wait states.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic ack, busy, err;
  logic [31:0] rdata;

  logic req0 = 1'b0;
  logic ack0, busy0, err0;
  logic [31:0] rdata0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [int];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy), .err(err)
  );

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .wr(1'b0), .addr(32'h0),
    .wdata(32'h0), .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    int lat;
    int idx;
    logic mis;
    logic known;
    logic [31:0] exp_r;
    idx = int'(a[9:2]);
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    known = 1'b1;
    exp_r = '0;
    if (!w && !mis) begin
      if (model.exists(idx)) exp_r = model[idx];
      else known = 1'b0;
    end
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; wr = ~w; addr = '1; wdata = '1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_err"}, 32'(err), 32'(mis));
    if (known) check({tag, "_rdata"}, rdata, exp_r);
    if (w && !mis) model[idx] = d;
    @(posedge clk);
    #1;
    check({tag, "_ackdrop"}, 32'(ack), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    txn(1'b1, 32'h10, 32'hDEADBEEF, "st10");
    txn(1'b0, 32'h10, 32'h0, "ld10");

    txn(1'b1, 32'h404, 32'h12345678, "st404");
    txn(1'b0, 32'h004, 32'h0, "ld004");

    txn(1'b1, 32'h20, 32'h11112222, "st20");
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("abort_noack", 32'(ack), 32'd0);
    end
    txn(1'b0, 32'h20, 32'h0, "ld20_abort");

    txn(1'b1, 32'h22, 32'h5A5A5A5A, "st22");
    txn(1'b0, 32'h20, 32'h0, "ld20_align");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_F03C;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      txn(1'($urandom), a, $urandom, "rand");
    end

    @(negedge clk);
    req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("w0_ack", 32'(ack0), 32'(i % 2));
    end
    req0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
